// File: rtl/calendar_pkg.sv
// Shared field indices, field ranges and calendar helpers for calendar_chain.
// The leap rule follows CALENDAR_CENTURY_EN when that macro is defined.
package calendar_pkg;

  localparam logic [2:0] FLD_SEC  = 3'd0;
  localparam logic [2:0] FLD_MIN  = 3'd1;
  localparam logic [2:0] FLD_HOUR = 3'd2;
  localparam logic [2:0] FLD_DAY  = 3'd3;
  localparam logic [2:0] FLD_MON  = 3'd4;
  localparam logic [2:0] FLD_YEAR = 3'd5;
  localparam logic [2:0] FLD_CENT = 3'd6;

  localparam logic [5:0] SEC_MIN  = 6'd0;
  localparam logic [5:0] SEC_MAX  = 6'd59;
  localparam logic [5:0] MIN_MIN  = 6'd0;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [4:0] HOUR_MIN = 5'd0;
  localparam logic [4:0] HOUR_MAX = 5'd23;
  localparam logic [4:0] DAY_MIN  = 5'd1;
  localparam logic [3:0] MON_MIN  = 4'd1;
  localparam logic [3:0] MON_MAX  = 4'd12;
  localparam logic [6:0] CENT_MIN = 7'd0;
  localparam logic [6:0] CENT_MAX = 7'd99;

  function automatic logic [4:0] days_in_month(input logic [3:0] month, input logic leap);
    case (month)
      4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
      4'd2:                    return leap ? 5'd29 : 5'd28;
      default:                 return 5'd31;
    endcase
  endfunction

  // Year 0 is a century year: only every fourth century is leap.
  function automatic logic is_leap(input logic [31:0] year, input logic [6:0] century);
`ifdef CALENDAR_CENTURY_EN
    return (year[1:0] == 2'b00) && ((year != 32'd0) || (century[1:0] == 2'b00));
`else
    return (year[1:0] == 2'b00) || (century == 7'd127 && 1'b0);
`endif
  endfunction

endpackage

// File: rtl/calendar_chain_field.sv
// Next-value logic for one calendar field: wrap counter with runtime maximum,
// ripple carry out, and clamp of an out-of-range value to a new maximum.
module cal_field #(
  parameter int             W   = 6,
  parameter logic [W-1:0]   MIN = '0
) (
  input  logic [W-1:0] value_i,
  input  logic [W-1:0] max_i,
  input  logic [W-1:0] clamp_max_i,
  input  logic         inc_i,
  input  logic         dec_i,
  input  logic         carry_i,
  output logic [W-1:0] value_o,
  output logic         carry_o
);

  logic up, dn, at_max, at_min;

  always_comb begin
    up      = inc_i | carry_i;
    dn      = dec_i;
    at_max  = (value_i == max_i);
    at_min  = (value_i == MIN);
    carry_o = carry_i & at_max;
    value_o = value_i;
    if (up && !dn) begin
      value_o = at_max ? MIN : value_i + 1'b1;
    end else if (dn && !up) begin
      value_o = at_min ? max_i : value_i - 1'b1;
    end else if (value_i > clamp_max_i) begin
      // A month/year change shrank the range underneath an untouched field.
      value_o = clamp_max_i;
    end
  end

endmodule

// File: rtl/calendar_chain.sv
// Second-to-year calendar with ripple carry, set mode and 12/24 h view.
// Define CALENDAR_CENTURY_EN to add the century field and full Gregorian leap rule.
module calendar_chain
  import calendar_pkg::*;
#(
  parameter int YEAR_W        = 7,
  parameter int YEAR_MAX      = 99,
  parameter int CENTURY_RESET = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              set_mode,
  input  logic [2:0]        field_sel,
  input  logic              adj_inc,
  input  logic              adj_dec,
  input  logic              mode_12h,
  output logic [5:0]        second,
  output logic [5:0]        minute,
  output logic [4:0]        hour,
  output logic [4:0]        hour_disp,
  output logic              pm,
  output logic [4:0]        day,
  output logic [3:0]        month,
  output logic [YEAR_W-1:0] year,
  output logic [4:0]        day_max,
  output logic              year_wrap
`ifdef CALENDAR_CENTURY_EN
  ,
  output logic [6:0]        century
`endif
);

  localparam logic [YEAR_W-1:0] YR_MAX   = YEAR_W'(YEAR_MAX);
  localparam logic [6:0]        CENT_RST = 7'(CENTURY_RESET);

  logic [5:0]        sec_q, sec_d, min_q, min_d;
  logic [4:0]        hour_q, hour_d, day_q, day_d, day_max_d;
  logic [3:0]        mon_q, mon_d;
  logic [YEAR_W-1:0] year_q, year_d;
  logic [6:0]        cent_q, cent_d;
  logic              year_wrap_q;
  logic              c_sec, c_min, c_hour, c_day, c_mon, c_year;
  logic              run, adj_up, adj_dn;

  assign run    = tick & ~set_mode;
  assign adj_up = set_mode & adj_inc;
  assign adj_dn = set_mode & adj_dec;

  // Day range for wrapping uses the current date; clamping uses the next one.
  assign day_max   = days_in_month(mon_q, is_leap(32'(year_q), cent_q));
  assign day_max_d = days_in_month(mon_d, is_leap(32'(year_d), cent_d));

  cal_field #(.W(6), .MIN(SEC_MIN)) u_sec (
    .value_i(sec_q), .max_i(SEC_MAX), .clamp_max_i(SEC_MAX),
    .inc_i(adj_up && field_sel == FLD_SEC), .dec_i(adj_dn && field_sel == FLD_SEC),
    .carry_i(run), .value_o(sec_d), .carry_o(c_sec));

  cal_field #(.W(6), .MIN(MIN_MIN)) u_min (
    .value_i(min_q), .max_i(MIN_MAX), .clamp_max_i(MIN_MAX),
    .inc_i(adj_up && field_sel == FLD_MIN), .dec_i(adj_dn && field_sel == FLD_MIN),
    .carry_i(c_sec), .value_o(min_d), .carry_o(c_min));

  cal_field #(.W(5), .MIN(HOUR_MIN)) u_hour (
    .value_i(hour_q), .max_i(HOUR_MAX), .clamp_max_i(HOUR_MAX),
    .inc_i(adj_up && field_sel == FLD_HOUR), .dec_i(adj_dn && field_sel == FLD_HOUR),
    .carry_i(c_min), .value_o(hour_d), .carry_o(c_hour));

  cal_field #(.W(5), .MIN(DAY_MIN)) u_day (
    .value_i(day_q), .max_i(day_max), .clamp_max_i(day_max_d),
    .inc_i(adj_up && field_sel == FLD_DAY), .dec_i(adj_dn && field_sel == FLD_DAY),
    .carry_i(c_hour), .value_o(day_d), .carry_o(c_day));

  cal_field #(.W(4), .MIN(MON_MIN)) u_mon (
    .value_i(mon_q), .max_i(MON_MAX), .clamp_max_i(MON_MAX),
    .inc_i(adj_up && field_sel == FLD_MON), .dec_i(adj_dn && field_sel == FLD_MON),
    .carry_i(c_day), .value_o(mon_d), .carry_o(c_mon));

  cal_field #(.W(YEAR_W), .MIN('0)) u_year (
    .value_i(year_q), .max_i(YR_MAX), .clamp_max_i(YR_MAX),
    .inc_i(adj_up && field_sel == FLD_YEAR), .dec_i(adj_dn && field_sel == FLD_YEAR),
    .carry_i(c_mon), .value_o(year_d), .carry_o(c_year));

`ifdef CALENDAR_CENTURY_EN
  logic c_cent;

  cal_field #(.W(7), .MIN(CENT_MIN)) u_cent (
    .value_i(cent_q), .max_i(CENT_MAX), .clamp_max_i(CENT_MAX),
    .inc_i(adj_up && field_sel == FLD_CENT), .dec_i(adj_dn && field_sel == FLD_CENT),
    .carry_i(c_year), .value_o(cent_d), .carry_o(c_cent));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cent_q <= CENT_RST;
    else       cent_q <= cent_d;
  end

  assign century = cent_q;
`else
  assign cent_q = CENT_RST;
  assign cent_d = CENT_RST;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sec_q       <= SEC_MIN;
      min_q       <= MIN_MIN;
      hour_q      <= HOUR_MIN;
      day_q       <= DAY_MIN;
      mon_q       <= MON_MIN;
      year_q      <= '0;
      year_wrap_q <= 1'b0;
    end else begin
      sec_q       <= sec_d;
      min_q       <= min_d;
      hour_q      <= hour_d;
      day_q       <= day_d;
      mon_q       <= mon_d;
      year_q      <= year_d;
      year_wrap_q <= c_year;
    end
  end

  always_comb begin
    hour_disp = hour_q;
    if (mode_12h) begin
      if (hour_q == 5'd0)       hour_disp = 5'd12;
      else if (hour_q > 5'd12)  hour_disp = hour_q - 5'd12;
    end
  end

  assign pm        = (hour_q >= 5'd12);
  assign second    = sec_q;
  assign minute    = min_q;
  assign hour      = hour_q;
  assign day       = day_q;
  assign month     = mon_q;
  assign year      = year_q;
  assign year_wrap = year_wrap_q;

endmodule

// File: tb/tb_calendar_chain.sv
// Self-checking bench for calendar_chain (default build, YEAR_MAX = 99).
module tb_calendar_chain;

  logic       clk, reset, tick, set_mode, adj_inc, adj_dec, mode_12h;
  logic [2:0] field_sel;
  logic [5:0] second, minute;
  logic [4:0] hour, hour_disp, day, day_max;
  logic       pm, year_wrap;
  logic [3:0] month;
  logic [6:0] year;
`ifdef CALENDAR_CENTURY_EN
  logic [6:0] century;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [2:0] F_S = 3'd0, F_M = 3'd1, F_H = 3'd2, F_D = 3'd3, F_MO = 3'd4, F_Y = 3'd5;

  typedef struct packed {
    logic [5:0] s;
    logic [5:0] m;
    logic [4:0] h;
    logic [4:0] d;
    logic [3:0] mo;
    logic [6:0] y;
    logic       w;
    logic [4:0] hd;
    logic       pm;
  } exp_t;

  typedef struct packed {
    logic       sm;
    logic [2:0] fs;
    logic       inc;
    logic       dec;
    logic       tk;
    logic       m12;
    exp_t       e;
  } vec_t;

  exp_t exp_q[$];
  vec_t tbl[$];
  exp_t rst_e;

  calendar_chain dut (
    .clk(clk), .reset(reset), .tick(tick), .set_mode(set_mode), .field_sel(field_sel),
    .adj_inc(adj_inc), .adj_dec(adj_dec), .mode_12h(mode_12h),
    .second(second), .minute(minute), .hour(hour), .hour_disp(hour_disp), .pm(pm),
    .day(day), .month(month), .year(year), .day_max(day_max), .year_wrap(year_wrap)
`ifdef CALENDAR_CENTURY_EN
    , .century(century)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk_exp(int s, int m, int h, int d, int mo, int y, logic w, logic m12);
    exp_t e;
    e.s  = 6'(s);
    e.m  = 6'(m);
    e.h  = 5'(h);
    e.d  = 5'(d);
    e.mo = 4'(mo);
    e.y  = 7'(y);
    e.w  = w;
    e.pm = (h >= 12);
    if (!m12)                   e.hd = 5'(h);
    else if (h == 0 || h == 12) e.hd = 5'd12;
    else                        e.hd = 5'(h % 12);
    return e;
  endfunction

  function automatic vec_t mk(logic sm, logic [2:0] fs, logic inc, logic dec, logic tk, logic m12,
                              int s, int m, int h, int d, int mo, int y, logic w);
    vec_t v;
    v.sm  = sm;
    v.fs  = fs;
    v.inc = inc;
    v.dec = dec;
    v.tk  = tk;
    v.m12 = m12;
    v.e   = mk_exp(s, m, h, d, mo, y, w, m12);
    return v;
  endfunction

  task automatic check(input string name, input exp_t e);
    exp_t g;
    g = {second, minute, hour, day, month, year, year_wrap, hour_disp, pm};
    n_chk++;
    if (g === e) n_pass++;
    else $display("FAIL %s: got %0d:%0d:%0d %0d/%0d/%0d wrap=%0d hd=%0d pm=%0d, expected %0d:%0d:%0d %0d/%0d/%0d wrap=%0d hd=%0d pm=%0d",
                  name, g.h, g.m, g.s, g.d, g.mo, g.y, g.w, g.hd, g.pm,
                  e.h, e.m, e.s, e.d, e.mo, e.y, e.w, e.hd, e.pm);
  endtask

  task automatic step(input string name, input vec_t v);
    @(negedge clk);
    set_mode  = v.sm;
    field_sel = v.fs;
    adj_inc   = v.inc;
    adj_dec   = v.dec;
    tick      = v.tk;
    mode_12h  = v.m12;
    exp_q.push_back(v.e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_chk++;
      $display("FAIL %s: scoreboard empty, got nothing to compare", name);
    end else begin
      check(name, exp_q.pop_front());
    end
  endtask

  task automatic idle_inputs();
    set_mode  = 1'b0;
    field_sel = 3'd0;
    adj_inc   = 1'b0;
    adj_dec   = 1'b0;
    tick      = 1'b0;
    mode_12h  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_e = mk_exp(0, 0, 0, 1, 1, 0, 1'b0, 1'b0);

    // preload 23:59:59 31/12/99 then wrap the whole calendar
    tbl.push_back(mk(1, F_S,  0, 1, 0, 0, 59,  0,  0,  1,  1,  0, 0));
    tbl.push_back(mk(1, F_M,  0, 1, 0, 0, 59, 59,  0,  1,  1,  0, 0));
    tbl.push_back(mk(1, F_H,  0, 1, 0, 0, 59, 59, 23,  1,  1,  0, 0));
    tbl.push_back(mk(1, F_D,  0, 1, 0, 0, 59, 59, 23, 31,  1,  0, 0));
    tbl.push_back(mk(1, F_MO, 0, 1, 0, 0, 59, 59, 23, 31, 12,  0, 0));
    tbl.push_back(mk(1, F_Y,  0, 1, 0, 0, 59, 59, 23, 31, 12, 99, 0));
    tbl.push_back(mk(0, 0,    0, 0, 1, 0,  0,  0,  0,  1,  1,  0, 1));
    tbl.push_back(mk(0, 0,    0, 0, 0, 0,  0,  0,  0,  1,  1,  0, 0));
    tbl.push_back(mk(0, 0,    0, 0, 1, 0,  1,  0,  0,  1,  1,  0, 0));
    // set mode: dropped tick, inc+dec together, unused select, minute wrap without carry
    tbl.push_back(mk(1, 0,    0, 0, 1, 0,  1,  0,  0,  1,  1,  0, 0));
    tbl.push_back(mk(1, F_S,  1, 1, 0, 0,  1,  0,  0,  1,  1,  0, 0));
    tbl.push_back(mk(1, 3'd7, 1, 0, 0, 0,  1,  0,  0,  1,  1,  0, 0));
    tbl.push_back(mk(1, F_M,  0, 1, 0, 0,  1, 59,  0,  1,  1,  0, 0));
    tbl.push_back(mk(1, F_M,  1, 0, 0, 0,  1,  0,  0,  1,  1,  0, 0));
    tbl.push_back(mk(1, F_H,  0, 1, 0, 0,  1,  0, 23,  1,  1,  0, 0));
    // day clamp on month and year changes
    tbl.push_back(mk(1, F_D,  0, 1, 0, 0,  1,  0, 23, 31,  1,  0, 0));
    tbl.push_back(mk(1, F_Y,  1, 0, 0, 0,  1,  0, 23, 31,  1,  1, 0));
    tbl.push_back(mk(1, F_MO, 1, 0, 0, 0,  1,  0, 23, 28,  2,  1, 0));
    tbl.push_back(mk(1, F_MO, 0, 1, 0, 0,  1,  0, 23, 28,  1,  1, 0));
    tbl.push_back(mk(1, F_Y,  0, 1, 0, 0,  1,  0, 23, 28,  1,  0, 0));
    tbl.push_back(mk(1, F_MO, 1, 0, 0, 0,  1,  0, 23, 28,  2,  0, 0));
    tbl.push_back(mk(1, F_D,  1, 0, 0, 0,  1,  0, 23, 29,  2,  0, 0));
    tbl.push_back(mk(1, F_D,  1, 0, 0, 0,  1,  0, 23,  1,  2,  0, 0));
    tbl.push_back(mk(1, F_D,  0, 1, 0, 0,  1,  0, 23, 29,  2,  0, 0));
    tbl.push_back(mk(1, F_Y,  1, 0, 0, 0,  1,  0, 23, 28,  2,  1, 0));
    // 28/02 rollover in a common year, then in a leap year
    tbl.push_back(mk(1, F_M,  0, 1, 0, 0,  1, 59, 23, 28,  2,  1, 0));
    tbl.push_back(mk(1, F_S,  0, 1, 0, 0,  0, 59, 23, 28,  2,  1, 0));
    tbl.push_back(mk(1, F_S,  0, 1, 0, 0, 59, 59, 23, 28,  2,  1, 0));
    tbl.push_back(mk(0, 0,    0, 0, 1, 0,  0,  0,  0,  1,  3,  1, 0));
    tbl.push_back(mk(1, F_MO, 0, 1, 0, 0,  0,  0,  0,  1,  2,  1, 0));
    tbl.push_back(mk(1, F_D,  0, 1, 0, 0,  0,  0,  0, 28,  2,  1, 0));
    tbl.push_back(mk(1, F_H,  0, 1, 0, 0,  0,  0, 23, 28,  2,  1, 0));
    tbl.push_back(mk(1, F_M,  0, 1, 0, 0,  0, 59, 23, 28,  2,  1, 0));
    tbl.push_back(mk(1, F_S,  0, 1, 0, 0, 59, 59, 23, 28,  2,  1, 0));
    tbl.push_back(mk(1, F_Y,  0, 1, 0, 0, 59, 59, 23, 28,  2,  0, 0));
    tbl.push_back(mk(0, 0,    0, 0, 1, 0,  0,  0,  0, 29,  2,  0, 0));
    tbl.push_back(mk(0, 0,    0, 0, 1, 0,  1,  0,  0, 29,  2,  0, 0));
    tbl.push_back(mk(1, 0,    0, 0, 1, 0,  1,  0,  0, 29,  2,  0, 0));
    tbl.push_back(mk(0, 0,    0, 0, 1, 1,  2,  0,  0, 29,  2,  0, 0));
    // leap year 4 versus years 1..3
    tbl.push_back(mk(1, F_Y,  1, 0, 0, 0,  2,  0,  0, 28,  2,  1, 0));
    tbl.push_back(mk(1, F_Y,  1, 0, 0, 0,  2,  0,  0, 28,  2,  2, 0));
    tbl.push_back(mk(1, F_Y,  1, 0, 0, 0,  2,  0,  0, 28,  2,  3, 0));
    tbl.push_back(mk(1, F_Y,  1, 0, 0, 0,  2,  0,  0, 28,  2,  4, 0));
    tbl.push_back(mk(1, F_D,  1, 0, 0, 0,  2,  0,  0, 29,  2,  4, 0));
    tbl.push_back(mk(1, F_D,  1, 0, 0, 0,  2,  0,  0,  1,  2,  4, 0));
    tbl.push_back(mk(1, F_Y,  0, 1, 0, 0,  2,  0,  0,  1,  2,  3, 0));
    tbl.push_back(mk(1, F_D,  0, 1, 0, 0,  2,  0,  0, 28,  2,  3, 0));

    idle_inputs();
    reset = 1'b0;
    #1 reset = 1'b1;
    #2 check("reset_initial", rst_e);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) step($sformatf("vec%0d", i), tbl[i]);

    for (int i = 1; i <= 13; i++)
      step($sformatf("hour12_%0d", i), mk(1, F_H, 1, 0, 0, 1, 2, 0, i, 28, 2, 3, 0));
    step("hour24_13", mk(0, 0, 0, 0, 0, 0, 2, 0, 13, 28, 2, 3, 0));
    step("hour24_12", mk(1, F_H, 0, 1, 0, 0, 2, 0, 12, 28, 2, 3, 0));

    @(negedge clk);
    idle_inputs();
    #2 reset = 1'b1;
    #1 check("reset_mid_count", rst_e);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) step($sformatf("preload%0d", i), tbl[i]);
    @(negedge clk);
    idle_inputs();
    tick = 1'b1;
    #2 reset = 1'b1;
    #1 check("reset_before_wrap_edge", rst_e);
    @(posedge clk);
    #1 check("wrap_suppressed", rst_e);
    @(negedge clk);
    tick  = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1 check("after_reset_release", rst_e);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
